// File: rtl/regalu_seq_pkg.sv
// Shared codes for the register/ALU command sequencer: op codes, register
// codes, FSM states and the command legality rule.
package regalu_seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_DEC  = 3'd2;
  localparam logic [2:0] OP_MOVE = 3'd3;
  localparam logic [2:0] OP_ALU  = 3'd4;
  localparam logic [2:0] OP_READ = 3'd5;

  localparam logic [1:0] REG_A    = 2'd0;
  localparam logic [1:0] REG_B    = 2'd1;
  localparam logic [1:0] REG_C    = 2'd2;
  localparam logic [1:0] REG_ZERO = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  // dst code 3 names no register, so it is rejected for every op
  function automatic logic cmd_legal(input logic [2:0] op, input logic [1:0] dst);
    logic ok;
    if (dst == REG_ZERO) begin
      ok = 1'b0;
    end else begin
      case (op)
        OP_NOP, OP_MOVE, OP_READ: ok = 1'b1;
        OP_INC, OP_DEC:           ok = (dst != REG_C);
        OP_ALU:                   ok = (dst == REG_C);
        default:                  ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/regalu_seq_if.sv
// Command and response channels of the register/ALU sequencer.
interface regalu_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_src;
  logic [1:0] cmd_alu;
  logic [3:0] cmd_count;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_alu, cmd_count, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_alu, cmd_count, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/regalu_sequencer.sv
// Command-driven controller for the 3-register 4-bit ALU datapath.
// Define REGALU_SEQ_CMD_CHECK_EN to reject illegal commands with an err pulse.
module regalu_sequencer
  import regalu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  regalu_seq_if.slave io,
  output logic       in_sel,
  output logic [1:0] bus_sel,
  output logic [1:0] alu_op,
  output logic       dec_a,
  output logic       dec_b,
  output logic       load_a,
  output logic       load_b,
  output logic       load_c,
  input  logic [3:0] bus_in,
  output logic       busy,
`ifdef REGALU_SEQ_CMD_CHECK_EN
  output logic       err,
`endif
  output logic       done
);

`ifdef REGALU_SEQ_CMD_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] dst_q, dst_d;
  logic [1:0] src_q, src_d;
  logic [1:0] alu_q, alu_d;
  logic [3:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  logic       nop_done_q, nop_done_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic       repeat_s;
  logic       act_s;

  assign repeat_s = ((op_q == OP_INC) || (op_q == OP_DEC)) && (cnt_q != 4'd0);

  // state and latched-command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      dst_q      <= REG_A;
      src_q      <= REG_A;
      alu_q      <= 2'd0;
      cnt_q      <= 4'd0;
      illegal_q  <= 1'b0;
      nop_done_q <= 1'b0;
      rsp_data_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      src_q      <= src_d;
      alu_q      <= alu_d;
      cnt_q      <= cnt_d;
      illegal_q  <= illegal_d;
      nop_done_q <= nop_done_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // next-state, command capture and repeat counter
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dst_d      = dst_q;
    src_d      = src_q;
    alu_d      = alu_q;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q;
    nop_done_d = 1'b0;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (io.cmd_valid) begin
          op_d      = io.cmd_op;
          dst_d     = io.cmd_dst;
          src_d     = io.cmd_src;
          alu_d     = io.cmd_alu;
          cnt_d     = io.cmd_count;
          illegal_d = !cmd_legal(io.cmd_op, io.cmd_dst);
          state_d   = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        // an unchecked illegal command retires exactly like a NOP
        if (illegal_q || (op_q == OP_NOP)) begin
          state_d    = ST_IDLE;
          nop_done_d = !(illegal_q && CHECK_EN);
        end else if (op_q == OP_READ) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (repeat_s) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_STROBE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        rsp_data_d = bus_in;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (io.rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign act_s = (state_q != ST_IDLE) && !illegal_q;

  // datapath controls, strobes and handshake outputs
  always_comb begin
    in_sel       = 1'b0;
    bus_sel      = 2'd0;
    alu_op       = 2'd0;
    dec_a        = 1'b0;
    dec_b        = 1'b0;
    load_a       = 1'b0;
    load_b       = 1'b0;
    load_c       = 1'b0;
    io.cmd_ready = (state_q == ST_IDLE);
    io.rsp_valid = (state_q == ST_RESP);
    io.rsp_data  = rsp_data_q;
    busy         = (state_q != ST_IDLE);
    done         = nop_done_q
                 | ((state_q == ST_SETTLE) && !repeat_s)
                 | ((state_q == ST_RESP) && io.rsp_ready);
    if (act_s) begin
      in_sel  = (op_q == OP_MOVE);
      bus_sel = ((op_q == OP_MOVE) || (op_q == OP_READ)) ? src_q : 2'd0;
      alu_op  = (op_q == OP_ALU) ? alu_q : 2'd0;
      dec_a   = (op_q == OP_DEC);
      dec_b   = (op_q == OP_DEC);
    end else begin
      in_sel = 1'b0;
    end
    if (act_s && (state_q == ST_STROBE)) begin
      case (dst_q)
        REG_A:   load_a = 1'b1;
        REG_B:   load_b = 1'b1;
        REG_C:   load_c = 1'b1;
        default: load_a = 1'b0;
      endcase
    end else begin
      load_a = 1'b0;
    end
  end

`ifdef REGALU_SEQ_CMD_CHECK_EN
  assign err = (state_q == ST_SETUP) && illegal_q;
`endif

endmodule
